// File: rtl/latch_16_pkg.sv
// Shared width and word type for the 16-bit gated holding latch.
// Bit 0 is the MSB throughout ([0:WIDTH-1] bus order).
package latch_16_pkg;

    localparam int LATCH_16_WIDTH = 16;

    typedef logic [0:LATCH_16_WIDTH-1] word_t;

endpackage

// File: rtl/latch_16_cell.sv
// One bit of the gated latch: clocked hold flop plus output select.
// LATCH_16_REGISTERED_OUT_EN removes the transparent d->q path.
module latch_16_cell
    import latch_16_pkg::*;
(
    input  logic clk_sys,
    input  logic rst,
    input  logic d,
    input  logic c,
    output logic q
);

    logic r_h;

    // Reset wins over the gate; a low gate simply holds.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_h <= 1'b0;
        end else if (c) begin
            r_h <= d;
        end
    end

`ifdef LATCH_16_REGISTERED_OUT_EN
    assign q = r_h;
`else
    assign q = c ? d : r_h;
`endif

endmodule

// File: rtl/latch_16.sv
// 16-bit gated data latch built from clocked per-bit cells.
// Define LATCH_16_REGISTERED_OUT_EN for a fully registered q.
module latch_16
    import latch_16_pkg::*;
#(
    parameter int WIDTH = LATCH_16_WIDTH
) (
    input  logic             clk_sys,
    input  logic             rst,
    input  logic [0:WIDTH-1] d,
    input  logic             c,
    output logic [0:WIDTH-1] q
);

    logic [0:WIDTH-1] w_q;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        latch_16_cell u_cell (
            .clk_sys (clk_sys),
            .rst     (rst),
            .d       (d[gi]),
            .c       (c),
            .q       (w_q[gi])
        );
    end

    assign q = w_q;

endmodule

// File: tb/tb_latch_16.sv
// Bench for latch_16: directed scenarios plus randomized sweeps
// against a simple hold-value reference model.
module tb_latch_16;

    logic        clk_sys;
    logic        rst;
    logic [0:15] d;
    logic        c;
    logic [0:15] q;

    int          vectors;
    int          miscompares;
    logic [15:0] m_h;

    latch_16 dut (
        .clk_sys (clk_sys),
        .rst     (rst),
        .d       (d),
        .c       (c),
        .q       (q)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    function automatic logic [15:0] exp_q();
`ifdef LATCH_16_REGISTERED_OUT_EN
        return m_h;
`else
        return c ? d : m_h;
`endif
    endfunction

    task automatic step();
        @(posedge clk_sys);
        if (rst)    m_h = 16'h0000;
        else if (c) m_h = d;
        @(negedge clk_sys);
    endtask

    task automatic test_reset();
        rst = 1'b1; c = 1'b0; d = 16'h0000;
        step();
        rst = 1'b0;
        #1;
        vectors++;
        if (q !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset q=%h expected %h", q, 16'h0000);
        end
    endtask

    task automatic test_transparent();
        c = 1'b1; d = 16'hA5C3;
        #1;
`ifndef LATCH_16_REGISTERED_OUT_EN
        vectors++;
        if (q !== 16'hA5C3) begin
            miscompares++;
            $display("FAIL transparent_comb q=%h expected %h", q, 16'hA5C3);
        end
`endif
        step();
        #1;
        vectors++;
        if (q !== 16'hA5C3) begin
            miscompares++;
            $display("FAIL transparent_edge q=%h expected %h", q, 16'hA5C3);
        end
    endtask

    task automatic test_hold();
        c = 1'b1; d = 16'h1234;
        step();
        c = 1'b0; d = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            step();
            #1;
            vectors++;
            if (q !== 16'h1234) begin
                miscompares++;
                $display("FAIL hold[%0d] q=%h expected %h", i, q, 16'h1234);
            end
        end
    endtask

    task automatic test_gate_fall();
        c = 1'b1; d = 16'hFFFF;
        step();
        c = 1'b0; d = 16'h0F0F;
        #1;
        vectors++;
        if (q !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL gate_fall_now q=%h expected %h", q, 16'hFFFF);
        end
        step();
        #1;
        vectors++;
        if (q !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL gate_fall_edge q=%h expected %h", q, 16'hFFFF);
        end
    endtask

    task automatic test_reset_during_hold();
        c = 1'b1; d = 16'hBEEF;
        step();
        c = 1'b0; d = 16'h0000;
        step();
        #1;
        vectors++;
        if (q !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL pre_reset_hold q=%h expected %h", q, 16'hBEEF);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        vectors++;
        if (q !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_in_hold q=%h expected %h", q, 16'h0000);
        end
        c = 1'b1; d = 16'h8001;
        step();
        #1;
        vectors++;
        if (q !== 16'h8001) begin
            miscompares++;
            $display("FAIL post_reset_capture q=%h expected %h", q, 16'h8001);
        end
        c = 1'b0;
        step();
    endtask

    task automatic test_reset_while_open();
        c = 1'b1; d = 16'h5A5A; rst = 1'b1;
        #1;
`ifndef LATCH_16_REGISTERED_OUT_EN
        vectors++;
        if (q !== 16'h5A5A) begin
            miscompares++;
            $display("FAIL rst_open_comb q=%h expected %h", q, 16'h5A5A);
        end
`endif
        step();
        c = 1'b0;
        #1;
        vectors++;
        if (q !== 16'h0000) begin
            miscompares++;
            $display("FAIL rst_open_clear q=%h expected %h", q, 16'h0000);
        end
        rst = 1'b0; c = 1'b1; d = 16'hC3A5;
        step();
        c = 1'b0;
        #1;
        vectors++;
        if (q !== 16'hC3A5) begin
            miscompares++;
            $display("FAIL rst_open_capture q=%h expected %h", q, 16'hC3A5);
        end
    endtask

    task automatic test_sweep();
        logic [15:0] v;
        for (int i = 0; i < 2100; i++) begin
            if (i < 16)       v = 16'h8000 >> i;
            else if (i == 16) v = 16'h0000;
            else if (i == 17) v = 16'hFFFF;
            else if (i < 34)  v = ~(16'h8000 >> (i - 18));
            else              v = 16'($urandom);
            c = 1'b1; d = v;
            step();
            #1;
            vectors++;
            if (q !== v) begin
                miscompares++;
                $display("FAIL sweep_open v=%h q=%h expected %h", v, q, v);
            end
            c = 1'b0; d = 16'h0000;
            step();
            #1;
            vectors++;
            if (q !== v) begin
                miscompares++;
                $display("FAIL sweep_hold v=%h q=%h expected %h", v, q, v);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] e;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 31) == 0);
            c   = 1'($urandom);
            d   = 16'($urandom);
            #1;
            e = exp_q();
            vectors++;
            if (q !== e) begin
                miscompares++;
                $display("FAIL b2b_pre[%0d] q=%h expected %h", i, q, e);
            end
            step();
            #1;
            e = exp_q();
            vectors++;
            if (q !== e) begin
                miscompares++;
                $display("FAIL b2b_post[%0d] q=%h expected %h", i, q, e);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        m_h         = 16'h0000;
        rst         = 1'b1;
        c           = 1'b0;
        d           = 16'h0000;
        @(negedge clk_sys);
        test_reset();
        test_transparent();
        test_hold();
        test_gate_fall();
        test_reset_during_hold();
        test_reset_while_open();
        test_sweep();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
